// File: rtl/rf_pkg.sv
// Shared types and helpers for the regfile_mp register file.
// Optional parity storage and checking is enabled with RF_PARITY_EN.
package rf_pkg;

    localparam int RF_XLEN_DEF  = 32;
    localparam int RF_NREGS_DEF = 32;
    localparam int RF_MAX_W     = 64;

    typedef enum logic {
        RF_IDLE,
        RF_CLEAR
    } rf_state_t;

    // Even parity bit; callers zero-extend narrower data, which leaves the XOR unchanged.
    function automatic logic rf_parity(input logic [RF_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range/zero forcing, write-first bypass, optional parity check.
// Parity checking is present only when RF_PARITY_EN is defined.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEF,
    parameter int NREGS    = RF_NREGS_DEF,
    parameter int ZERO_REG = 1,
    parameter int SW       = RF_XLEN_DEF,
    parameter int AW       = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_i,
    input  logic            rd_en_i,
    input  logic [AW-1:0]   rd_addr_i,
    input  logic [SW-1:0]   mem_i [NREGS],
    input  logic            wr_acc_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0] rd_data_o
`ifdef RF_PARITY_EN
    ,
    output logic            rd_perr_o
`endif
);

    logic [XLEN-1:0] data_q, data_d;
    logic [SW-1:0]   word;
    logic            hit_zero, in_range, bypass;

    always_comb begin
        hit_zero = (ZERO_REG != 0) && (rd_addr_i == '0);
        in_range = int'(rd_addr_i) < NREGS;
        bypass   = wr_acc_i && (wr_addr_i == rd_addr_i);
        word     = in_range ? mem_i[rd_addr_i] : '0;
    end

    // NOTE: every combinational output gets its default first so no path infers a latch.
    always_comb begin
        data_d = data_q;
        if (flush_i) begin
            data_d = '0;
        end else if (rd_en_i) begin
            if (hit_zero || !in_range) data_d = '0;
            else if (bypass)           data_d = wr_data_i;
            else                       data_d = word[XLEN-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign rd_data_o = data_q;

`ifdef RF_PARITY_EN
    logic perr_q, perr_d;

    always_comb begin
        perr_d = perr_q;
        if (flush_i) begin
            perr_d = 1'b0;
        end else if (rd_en_i) begin
            perr_d = !(hit_zero || !in_range || bypass) &&
                     (rf_parity(RF_MAX_W'(word[XLEN-1:0])) != word[XLEN]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) perr_q <= 1'b0;
        else       perr_q <= perr_d;
    end

    assign rd_perr_o = perr_q;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, hardwired x0 and a sequential clear sweep.
// Define RF_PARITY_EN to add a per-entry even-parity bit and the rd_perr output.
module regfile_mp
    import rf_pkg::*;
#(
    parameter int  XLEN     = RF_XLEN_DEF,
    parameter int  NREGS    = RF_NREGS_DEF,
    parameter int  NRD      = 2,
    parameter int  ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_req,
    output logic                ready,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data
`ifdef RF_PARITY_EN
    ,
    output logic [NRD-1:0]      rd_perr
`endif
);

`ifdef RF_PARITY_EN
    localparam int SW = XLEN + 1;
`else
    localparam int SW = XLEN;
`endif

    rf_state_t     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [SW-1:0] mem_q [NREGS];
    logic          idle, wr_acc, mem_we;
    logic [AW-1:0] mem_waddr;
    logic [SW-1:0] mem_wdata;

    assign idle  = (state_q == RF_IDLE);
    assign ready = idle;

    // A write is dropped while sweeping and in the cycle that starts a sweep.
    assign wr_acc = idle && !clear_req && wr_en && (int'(wr_addr) < NREGS) &&
                    !((ZERO_REG != 0) && (wr_addr == '0));

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == AW'(NREGS - 1)) begin
                    state_d = RF_IDLE;
                    ptr_d   = '0;
                end
            end
            default: begin
                if (clear_req) begin
                    state_d = RF_CLEAR;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RF_CLEAR;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
`ifdef RF_PARITY_EN
        mem_wdata = {rf_parity(RF_MAX_W'(wr_data)), wr_data};
`else
        mem_wdata = wr_data;
`endif
        if (state_q == RF_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end else if (wr_acc) begin
            mem_we = 1'b1;
        end
    end

    // NOTE: the array has no reset; the clear sweep zeroes it one entry per cycle instead.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        rf_read_port #(
            .XLEN(XLEN), .NREGS(NREGS), .ZERO_REG(ZERO_REG), .SW(SW), .AW(AW)
        ) u_port (
            .clk      (clk),
            .reset    (reset),
            .flush_i  (idle && clear_req),
            .rd_en_i  (rd_en[i] && idle),
            .rd_addr_i(rd_addr[i*AW +: AW]),
            .mem_i    (mem_q),
            .wr_acc_i (wr_acc),
            .wr_addr_i(wr_addr),
            .wr_data_i(wr_data),
            .rd_data_o(rd_data[i*XLEN +: XLEN])
`ifdef RF_PARITY_EN
            ,
            .rd_perr_o(rd_perr[i])
`endif
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a 32-entry and a 24-entry instance share stimulus
// and are compared every cycle against a behavioural model, plus directed sequences.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, clr, we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [1:0]  rden;
    logic [4:0]  ra0, ra1;
    logic        rdy_a, rdy_b;
    logic [63:0] rdd_a, rdd_b;
`ifdef RF_PARITY_EN
    logic [1:0]  perr_a, perr_b;
`endif

    regfile_mp dut (
        .clk(clk), .reset(rst), .clear_req(clr), .ready(rdy_a),
        .rd_en(rden), .rd_addr({ra1, ra0}), .rd_data(rdd_a),
        .wr_en(we), .wr_addr(waddr), .wr_data(wdata)
`ifdef RF_PARITY_EN
        , .rd_perr(perr_a)
`endif
    );

    regfile_mp #(.NREGS(24)) dut24 (
        .clk(clk), .reset(rst), .clear_req(clr), .ready(rdy_b),
        .rd_en(rden), .rd_addr({ra1, ra0}), .rd_data(rdd_b),
        .wr_en(we), .wr_addr(waddr), .wr_data(wdata)
`ifdef RF_PARITY_EN
        , .rd_perr(perr_b)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: index 0 models the 32-entry instance, index 1 the 24-entry one.
    int          nr [2] = '{32, 24};
    logic [31:0] m_mem  [2][32];
    bit          m_bad  [2][32];
    int          m_sweep[2];
    logic [31:0] m_rd   [2][2];
    bit          m_perr [2][2];

    task automatic model_edge();
        logic [4:0] a;
        bit         wr_ok;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                m_sweep[d] = nr[d];
                m_rd[d]    = '{32'h0, 32'h0};
                m_perr[d]  = '{0, 0};
            end else if (m_sweep[d] > 0) begin
                m_mem[d][nr[d] - m_sweep[d]] = 32'h0;
                m_bad[d][nr[d] - m_sweep[d]] = 0;
                m_sweep[d]--;
            end else if (clr) begin
                m_rd[d]    = '{32'h0, 32'h0};
                m_perr[d]  = '{0, 0};
                m_sweep[d] = nr[d];
            end else begin
                wr_ok = we && (int'(waddr) < nr[d]) && (waddr != 0);
                for (int p = 0; p < 2; p++) begin
                    if (rden[p]) begin
                        a = (p == 0) ? ra0 : ra1;
                        if (a == 0 || int'(a) >= nr[d]) begin
                            m_rd[d][p] = 32'h0; m_perr[d][p] = 0;
                        end else if (wr_ok && waddr == a) begin
                            m_rd[d][p] = wdata; m_perr[d][p] = 0;
                        end else begin
                            m_rd[d][p] = m_mem[d][a]; m_perr[d][p] = m_bad[d][a];
                        end
                    end
                end
                if (wr_ok) begin
                    m_mem[d][waddr] = wdata;
                    m_bad[d][waddr] = 0;
                end
            end
        end
    endtask

    task automatic compare_all();
        check("ready32", {63'h0, rdy_a}, {63'h0, m_sweep[0] == 0});
        check("ready24", {63'h0, rdy_b}, {63'h0, m_sweep[1] == 0});
        check("rd32",    rdd_a, {m_rd[0][1], m_rd[0][0]});
        check("rd24",    rdd_b, {m_rd[1][1], m_rd[1][0]});
`ifdef RF_PARITY_EN
        check("perr32",  {62'h0, perr_a}, {62'h0, m_perr[0][1], m_perr[0][0]});
        check("perr24",  {62'h0, perr_b}, {62'h0, m_perr[1][1], m_perr[1][0]});
`endif
    endtask

    // Inputs change at the falling edge; outputs are checked 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic idle_in();
        clr = 0; we = 0; waddr = '0; wdata = '0; rden = '0; ra0 = '0; ra1 = '0;
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [1:0]  rden;
        logic [4:0]  ra0, ra1;
        logic [31:0] e0, e1;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int c_a, c_b, cnt;
        foreach (m_mem[d, i]) begin m_mem[d][i] = '0; m_bad[d][i] = 0; end
        m_sweep = '{0, 0};
        m_rd    = '{'{32'h0, 32'h0}, '{32'h0, 32'h0}};
        m_perr  = '{'{0, 0}, '{0, 0}};

        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 2'b00, 5'd0, 5'd0, 32'h0,        32'h0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0};
        tbl[2] = '{1'b1, 5'd0, 32'h00001234, 2'b00, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd0, 5'd0, 32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd7, 32'hCAFEF00D, 2'b11, 5'd7, 5'd7, 32'hCAFEF00D, 32'hCAFEF00D};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        2'b01, 5'd5, 5'd1, 32'hDEADBEEF, 32'hCAFEF00D};
        tbl[6] = '{1'b1, 5'd5, 32'h0000A5A5, 2'b11, 5'd5, 5'd5, 32'h0000A5A5, 32'h0000A5A5};
        tbl[7] = '{1'b0, 5'd0, 32'h0,        2'b11, 5'd5, 5'd7, 32'h0000A5A5, 32'hCAFEF00D};

        // Reset, then measure sweep length of both instances.
        idle_in();
        rst = 1;
        step();
        rst = 0;
        c_a = -1; c_b = -1;
        for (int i = 1; i <= 100; i++) begin
            step();
            if (rdy_a && c_a < 0) c_a = i;
            if (rdy_b && c_b < 0) c_b = i;
            if (c_a >= 0 && c_b >= 0) break;
        end
        check("sweep_len32", 64'(c_a), 64'd32);
        check("sweep_len24", 64'(c_b), 64'd24);

        for (int i = 0; i < 32; i++) begin
            rden = 2'b11; ra0 = 5'(i); ra1 = 5'(31 - i);
            step();
            check("read_all_zero", rdd_a, 64'h0);
        end

        // Basic writes, x0 hardwiring, shared-address bypass and read-enable hold.
        foreach (tbl[i]) begin
            we = tbl[i].we; waddr = tbl[i].waddr; wdata = tbl[i].wdata;
            rden = tbl[i].rden; ra0 = tbl[i].ra0; ra1 = tbl[i].ra1;
            step();
            check($sformatf("tbl%0d_p0", i), {32'h0, rdd_a[31:0]},  {32'h0, tbl[i].e0});
            check($sformatf("tbl%0d_p1", i), {32'h0, rdd_a[63:32]}, {32'h0, tbl[i].e1});
        end

        // Clear sweep: writes during the sweep are lost and a second request does not extend it.
        idle_in();
        we = 1; waddr = 5'd9; wdata = 32'h55;
        step();
        we = 0; clr = 1;
        step();
        check("clear_ready_low", {63'h0, rdy_a}, 64'h0);
        cnt = 0;
        we = 1; waddr = 5'd9; wdata = 32'hFF; rden = 2'b11; ra0 = 5'd9; ra1 = 5'd9;
        for (int i = 0; i < 100 && !rdy_a; i++) begin
            clr = (i == 5);
            step();
            cnt++;
            if (i < 31) check("sweep_rd_zero", rdd_a, 64'h0);
        end
        check("clear_len", 64'(cnt), 64'd32);
        idle_in();
        rden = 2'b01; ra0 = 5'd9;
        step();
        check("x9_after_clear", {32'h0, rdd_a[31:0]}, 64'h0);

        // Reset partway through a sweep restarts it.
        rst = 1;
        step();
        rst = 0;
        for (int i = 0; i < 10; i++) step();
        rst = 1;
        step();
        check("reset_mid_ready", {63'h0, rdy_a}, 64'h0);
        rst = 0;
        cnt = 0;
        for (int i = 0; i < 100 && !rdy_a; i++) begin
            step();
            cnt++;
        end
        check("resweep_len", 64'(cnt), 64'd32);

        // Address 30 is out of range on the 24-entry instance only.
        idle_in();
        we = 1; waddr = 5'd30; wdata = 32'h77;
        step();
        idle_in();
        rden = 2'b01; ra0 = 5'd30;
        step();
        check("oor24_read", {32'h0, rdd_b[31:0]}, 64'h0);
        check("x30_on32",   {32'h0, rdd_a[31:0]}, 64'h77);

`ifdef RF_PARITY_EN
        idle_in();
        we = 1; waddr = 5'd3; wdata = 32'h00000F0F;
        step();
        idle_in();
        dut.mem_q[3][0] = ~dut.mem_q[3][0];
        m_mem[0][3][0] = ~m_mem[0][3][0];
        m_bad[0][3]    = 1;
        rden = 2'b01; ra0 = 5'd3;
        step();
        check("perr_flag",   {63'h0, perr_a[0]}, 64'h1);
        check("perr_data",   {32'h0, rdd_a[31:0]}, 64'h00000F0E);
        idle_in();
        we = 1; waddr = 5'd3; wdata = 32'h00000F0F;
        step();
        idle_in();
        rden = 2'b01; ra0 = 5'd3;
        step();
        check("perr_cleared", {63'h0, perr_a[0]}, 64'h0);
`endif

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst   = ($urandom_range(0, 399) == 0);
            clr   = ($urandom_range(0, 79) == 0);
            we    = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom();
            rden  = 2'($urandom_range(0, 3));
            ra0   = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            ra1   = ($urandom_range(0, 3) == 0) ? ra0   : 5'($urandom_range(0, 31));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
